mem_dump_tx: RTL and testbench
==============================

Name: mem_dump_tx

Overview:
- Reader/transmitter on the far side of the processor's data-memory debug port (memsel / addrcheck / datacheck).
- On a start pulse, takes over the port and sweeps a word-aligned address range.
- Captures each 12-bit datacheck value and sends it off-chip as UART 8N1 bytes.
- Sits at the top level beside the core; the only link between them is the debug port.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (must be >= 2).
- READ_LAT, 2, clk cycles from an addrcheck change to a valid datacheck sample (must be >= 1).
- ADDR_STEP, 4, address increment between samples (byte address, word stride).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request; sampled only in IDLE.
- addr_lo  input  12  first address; latched on an accepted start.
- addr_hi  input  12  last address, inclusive; latched on an accepted start.
- datacheck  input  12  data returned by the memory debug port.
- memsel  output  1  selects the debug port in data memory; high for the whole dump.
- addrcheck  output  12  address driven to the debug port.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from an accepted start until the final stop bit ends.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: memsel=0, addrcheck=0, tx=1, busy=0, done=0, all FSMs in IDLE.
- Reset asserted mid-dump or mid-byte aborts at once: tx returns to 1 asynchronously, with no partial-frame completion.
- Main FSM states: IDLE, SETUP, WAIT, SAMPLE, TX_HI, TX_LO, NEXT, FIN.
- IDLE, start=1: latch addr_lo and addr_hi, set busy=1 on the next edge.
  - If addr_lo > addr_hi: go to FIN; no memsel, no bytes sent.
  - Otherwise: go to SETUP.
- start while busy is ignored. start in the same cycle as FIN is ignored.
- SETUP: memsel=1, addrcheck=cur_addr; wait counter loaded with READ_LAT-1; go to WAIT.
- WAIT: count down; at 0 go to SAMPLE.
- SAMPLE: register datacheck into a 12-bit hold register; go to TX_HI.
- TX_HI: send the byte {4'h0, hold[11:8]}. TX_LO: send the byte hold[7:0]. Each state waits for byte-done.
- NEXT:
  - If cur_addr + ADDR_STEP > addr_hi, or the 13-bit sum carries past 12'hFFF: go to FIN. There is no wrap-around.
  - Otherwise: cur_addr += ADDR_STEP and go to SETUP.
- FIN: memsel=0, busy=0, done=1 for exactly one cycle; go to IDLE.
- addrcheck holds its last value after the dump. memsel stays 1 from SETUP through the last TX_LO.
- UART sub-FSM states: IDLE, START, DATA, STOP.
  - Send request loads the byte.
  - START drives tx=0 for CLKS_PER_BIT cycles.
  - DATA sends 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP drives tx=1 for CLKS_PER_BIT cycles.
  - byte-done pulses on the last STOP cycle.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back bytes have no extra idle cycles between the stop bit and the next start bit.
- Per-word time: 1 (SETUP) + READ_LAT + 1 (SAMPLE) + 20*CLKS_PER_BIT + 1 (NEXT) cycles.
- Words sent: floor((addr_hi - addr_lo)/ADDR_STEP) + 1 when addr_lo <= addr_hi.

Optional Feature:
- Macro: MEM_DUMP_ADDR_HDR_EN.
- Defined: two header bytes precede each data pair, sent from new states HDR_HI and HDR_LO between SAMPLE and TX_HI.
  - Bytes: {4'h0, cur_addr[11:8]}, then cur_addr[7:0].
  - Each word is 4 bytes, and per-word time grows by 20*CLKS_PER_BIT.
- Undefined: HDR states are absent; 2 bytes per word.

Test Plan:
- Single word: CLKS_PER_BIT=4, READ_LAT=2, addr_lo=addr_hi=12'h010, datacheck=12'hA5C.
  - Bytes 0x0A then 0x5C seen on tx, LSB first.
  - memsel high throughout; done pulses once; busy low 1 cycle after the last stop bit.
- Range: addr_lo=0, addr_hi=12, model memory returns addr+1.
  - addrcheck steps 0,4,8,12.
  - Bytes 00 01, 00 05, 00 09, 00 0D; exactly 4 words.
- Empty range: addr_lo=8, addr_hi=4.
  - tx stays 1, memsel never rises, done pulses 2 cycles after start.
- Top boundary: addr_lo=12'hFF8, addr_hi=12'hFFF.
  - Exactly 2 words (FF8, FFC); addrcheck never wraps to 0.
- Reset mid-byte: assert rst during bit 3 of the first byte.
  - tx=1, memsel=0, busy=0 immediately.
  - After release, a new start runs a full correct dump.
- start held high during a dump: no restart.
  - With MEM_DUMP_ADDR_HDR_EN, the word at 12'h004 with data 12'h123 emits 00 04 01 23.

Source files
------------

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: drives the data-memory debug port across an address range and streams each 12-bit word as UART 8N1 bytes.
// Optional macro MEM_DUMP_ADDR_HDR_EN prefixes every word with its address as two extra header bytes.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int READ_LAT     = 2,
  parameter int ADDR_STEP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] addr_lo,
  input  logic [11:0] addr_hi,
  input  logic [11:0] datacheck,
  output logic        memsel,
  output logic [11:0] addrcheck,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(READ_LAT - 1);
  localparam logic [12:0]   STEP      = 13'(ADDR_STEP);

`ifdef MEM_DUMP_ADDR_HDR_EN
  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_WAIT, S_SAMPLE, S_HDR_HI, S_HDR_LO, S_TX_HI, S_TX_LO, S_NEXT, S_FIN
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_WAIT, S_SAMPLE, S_TX_HI, S_TX_LO, S_NEXT, S_FIN
  } state_t;
`endif

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

  state_t        state, next_state;
  ustate_t       ustate, u_next;
  logic [11:0]   cur_addr;
  logic [11:0]   hi_lim;
  logic [11:0]   hold;
  logic [WW-1:0] wait_cnt;
  logic [12:0]   sum;
  logic          send;
  logic [7:0]    send_byte;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          byte_done;

  // The 13th bit of the sum catches a step past 12'hFFF so the sweep never wraps.
  assign sum       = {1'b0, cur_addr} + STEP;
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign byte_done = (ustate == U_STOP) && bit_end;

  // Main sequencer next-state; each byte request is raised on the cycle the previous byte ends.
  always_comb begin
    next_state = state;
    send       = 1'b0;
    send_byte  = 8'h00;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = (addr_lo > addr_hi) ? S_FIN : S_SETUP;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_SETUP: next_state = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = S_SAMPLE;
        end else begin
          next_state = S_WAIT;
        end
      end
`ifdef MEM_DUMP_ADDR_HDR_EN
      S_SAMPLE: begin
        send       = 1'b1;
        send_byte  = {4'h0, cur_addr[11:8]};
        next_state = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (byte_done) begin
          send       = 1'b1;
          send_byte  = cur_addr[7:0];
          next_state = S_HDR_LO;
        end else begin
          next_state = S_HDR_HI;
        end
      end
      S_HDR_LO: begin
        if (byte_done) begin
          send       = 1'b1;
          send_byte  = {4'h0, hold[11:8]};
          next_state = S_TX_HI;
        end else begin
          next_state = S_HDR_LO;
        end
      end
`else
      S_SAMPLE: begin
        send       = 1'b1;
        send_byte  = {4'h0, datacheck[11:8]};
        next_state = S_TX_HI;
      end
`endif
      S_TX_HI: begin
        if (byte_done) begin
          send       = 1'b1;
          send_byte  = hold[7:0];
          next_state = S_TX_LO;
        end else begin
          next_state = S_TX_HI;
        end
      end
      S_TX_LO: begin
        if (byte_done) begin
          next_state = S_NEXT;
        end else begin
          next_state = S_TX_LO;
        end
      end
      S_NEXT: begin
        if (sum[12] || (sum[11:0] > hi_lim)) begin
          next_state = S_FIN;
        end else begin
          next_state = S_SETUP;
        end
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Main sequencer state, address walk, sample hold and port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= 12'h000;
      hi_lim    <= 12'h000;
      hold      <= 12'h000;
      wait_cnt  <= '0;
      memsel    <= 1'b0;
      addrcheck <= 12'h000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == S_FIN);
      busy  <= (state == S_IDLE) ? start : ((next_state != S_FIN) && (next_state != S_IDLE));
      if ((state == S_IDLE) && start) begin
        cur_addr <= addr_lo;
        hi_lim   <= addr_hi;
      end
      if (state == S_SETUP) begin
        memsel    <= 1'b1;
        addrcheck <= cur_addr;
        wait_cnt  <= WAIT_INIT;
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WW'(1);
      end
      if (next_state == S_FIN) begin
        memsel <= 1'b0;
      end
      if (state == S_SAMPLE) begin
        hold <= datacheck;
      end
      if ((state == S_NEXT) && (next_state == S_SETUP)) begin
        cur_addr <= sum[11:0];
      end
    end
  end

  // UART next-state; a request arriving on the last stop cycle chains straight into a start bit.
  always_comb begin
    u_next = ustate;
    case (ustate)
      U_IDLE: begin
        if (send) begin
          u_next = U_START;
        end else begin
          u_next = U_IDLE;
        end
      end
      U_START: begin
        if (bit_end) begin
          u_next = U_DATA;
        end else begin
          u_next = U_START;
        end
      end
      U_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
          u_next = U_STOP;
        end else begin
          u_next = U_DATA;
        end
      end
      U_STOP: begin
        if (bit_end) begin
          u_next = send ? U_START : U_IDLE;
        end else begin
          u_next = U_STOP;
        end
      end
      default: u_next = U_IDLE;
    endcase
  end

  // UART bit timer, shift register and registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ustate  <= U_IDLE;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      ustate <= u_next;
      if (send || (ustate == U_IDLE) || bit_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (send) begin
        shreg   <= send_byte;
        bit_idx <= 3'd0;
        tx      <= 1'b0;
      end else if (bit_end) begin
        case (ustate)
          U_START: tx <= shreg[0];
          U_DATA: begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {1'b0, shreg[7:1]};
            tx      <= (bit_idx == 3'd7) ? 1'b1 : shreg[1];
          end
          U_STOP:  tx <= 1'b1;
          default: tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: expected bytes and addresses are queued as each dump is launched and
// popped by a UART receiver and a debug-port observer.
module tb_mem_dump_tx;

  localparam int CPB  = 4;
  localparam int RL   = 2;
  localparam int STEP = 4;
`ifdef MEM_DUMP_ADDR_HDR_EN
  localparam int BPW = 4;
`else
  localparam int BPW = 2;
`endif
  localparam int WORD_CYC = 1 + RL + 1 + BPW * 10 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] addr_lo = 12'h000;
  logic [11:0] addr_hi = 12'h000;
  logic [11:0] datacheck;
  logic        memsel, tx, busy, done;
  logic [11:0] addrcheck;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  int done_cnt = 0;
  int tx_low_cnt = 0;
  int memsel_glitch = 0;
  bit rst_seen = 1'b0;
  logic [7:0]  exp_q[$];
  logic [11:0] exp_addr[$];
  logic [11:0] seen_addr[$];

  mem_dump_tx #(.CLKS_PER_BIT(CPB), .READ_LAT(RL), .ADDR_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .datacheck(datacheck), .memsel(memsel), .addrcheck(addrcheck), .tx(tx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mem_model(input int m, input logic [11:0] a);
    case (m)
      0:       return 12'hA5C;
      1:       return a + 12'd1;
      default: return 12'h123;
    endcase
  endfunction

  always_comb datacheck = mem_model(mode, addrcheck);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge rst);
    rst_seen = 1'b1;
  end

  // Debug-port observer: records each newly presented address and flags memsel outside busy.
  initial begin
    logic        memsel_d;
    logic [11:0] addr_d;
    memsel_d = 1'b0;
    addr_d   = 12'h000;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (tx === 1'b0) tx_low_cnt++;
      if (memsel && (!memsel_d || addrcheck != addr_d)) seen_addr.push_back(addrcheck);
      if (memsel && !busy) memsel_glitch++;
      if (memsel_d && !memsel && busy) memsel_glitch++;
      memsel_d = memsel;
      addr_d   = addrcheck;
    end
  end

  // UART receiver sampling mid-bit; frames cut short by reset are discarded.
  initial forever begin
    logic [7:0] b;
    logic       sbit, pbit;
    @(negedge tx);
    rst_seen = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1 sbit = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 b[i] = tx;
    end
    repeat (CPB) @(posedge clk);
    #1 pbit = tx;
    if (!rst_seen) begin
      check("rx_framing", {30'd0, sbit, pbit}, 32'd1);
      if (exp_q.size() == 0) check("rx_unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic run_dump(input logic [11:0] lo, input logic [11:0] hi, input int m,
                          input bit hold_start, input string tag);
    int n, k, expect_cyc;
    bit got;
    logic [11:0] a, d;
    mode = m;
    exp_addr.delete();
    seen_addr.delete();
    done_cnt = 0;
    memsel_glitch = 0;
    n = (lo <= hi) ? (int'(hi) - int'(lo)) / STEP + 1 : 0;
    for (int i = 0; i < n; i++) begin
      a = lo + 12'(i * STEP);
      d = mem_model(m, a);
      exp_addr.push_back(a);
`ifdef MEM_DUMP_ADDR_HDR_EN
      exp_q.push_back({4'h0, a[11:8]});
      exp_q.push_back(a[7:0]);
`endif
      exp_q.push_back({4'h0, d[11:8]});
      exp_q.push_back(d[7:0]);
    end
    expect_cyc = n * WORD_CYC + 2;
    @(negedge clk);
    addr_lo = lo;
    addr_hi = hi;
    start   = 1'b1;
    got = 1'b0;
    k = 0;
    while (!got && k < expect_cyc + 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (!hold_start) start = 1'b0;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_done_cycle"}, k, expect_cyc);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_memsel_after"}, {31'd0, memsel}, 32'd0);
    check({tag, "_memsel_window"}, memsel_glitch, 32'd0);
    check({tag, "_bytes_left"}, exp_q.size(), 32'd0);
    check({tag, "_word_count"}, seen_addr.size(), n);
    for (int i = 0; i < n && i < seen_addr.size(); i++)
      check({tag, "_addr"}, {20'd0, seen_addr[i]}, {20'd0, exp_addr[i]});
    if (n > 0) check({tag, "_addr_hold"}, {20'd0, addrcheck}, {20'd0, exp_addr[n-1]});
  endtask

  initial begin
    int txl;
    repeat (3) @(negedge clk);
    check("reset_memsel", {31'd0, memsel}, 32'd0);
    check("reset_addrcheck", {20'd0, addrcheck}, 32'd0);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_dump(12'h010, 12'h010, 0, 1'b0, "single");
    run_dump(12'h000, 12'h00C, 1, 1'b0, "range");

    txl = tx_low_cnt;
    run_dump(12'h008, 12'h004, 1, 1'b0, "empty");
    check("empty_tx_idle", tx_low_cnt - txl, 32'd0);

    run_dump(12'hFF8, 12'hFFF, 1, 1'b0, "top");

    // Abort in the middle of data bit 3 of the first byte.
    mode = 1;
    @(negedge clk);
    addr_lo = 12'h000;
    addr_hi = 12'h00C;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    check("pre_rst_memsel", {31'd0, memsel}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_memsel", {31'd0, memsel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    run_dump(12'h000, 12'h00C, 1, 1'b0, "after_rst");

    run_dump(12'h020, 12'h02C, 1, 1'b1, "held_start");
    run_dump(12'h004, 12'h004, 2, 1'b0, "word4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
